sha3_padder: RTL

- Upstream stage of the SHA-3 permutation core.
- Accepts the message as a stream of 32-bit words from the AXI-side driver, applies SHA-3 multi-rate padding, and assembles rate-sized blocks.
- Presents each completed block, MSB-aligned to the selected rate, to the permutation through its `in`/`in_ready`/`ack` handshake.
- Latches the rate selection per message, so the permutation sees a stable `out_size` throughout the message.

---
 rtl/sha3_pkg.sv | 40 ++++
 rtl/sha3_padder_if.sv | 29 ++
 rtl/sha3_pad_word.sv | 59 +++++
 rtl/sha3_padder.sv | 116 +++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// sha3_pkg: shared constants and types for the SHA-3 padder slice.
//   - rate / words-per-block tables for the four rate selects
//   - SHA-3 multi-rate padding bytes
//   - padder FSM state type
package sha3_pkg;

  localparam int WORD_W = 32;

  localparam int RATE_576  = 576;
  localparam int RATE_832  = 832;
  localparam int RATE_1088 = 1088;
  localparam int RATE_1152 = 1152;

  localparam logic [5:0] WORDS_576  = 6'd18;
  localparam logic [5:0] WORDS_832  = 6'd26;
  localparam logic [5:0] WORDS_1088 = 6'd34;
  localparam logic [5:0] WORDS_1152 = 6'd36;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } state_t;

  // Number of 32-bit words in one rate-sized block.
  function automatic logic [5:0] words_per_block(input logic [1:0] sel);
    logic [5:0] n;
    case (sel)
      2'd0:    n = WORDS_576;
      2'd1:    n = WORDS_832;
      2'd2:    n = WORDS_1088;
      default: n = WORDS_1152;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sha3_padder_if.sv
// sha3_padder_if: bundles the padder's word-input and block-output signals.
//   master : message driver / permutation side (drives words and f_ack)
//   slave  : the padder itself
// Handshake: a word transfers on a rising clk edge where in_ready=1 and
// buffer_full=0. A block is valid while out_ready=1 and is retired by a
// single-cycle f_ack pulse; f_ack with out_ready=0 has no effect.
interface sha3_padder_if #(parameter int MAX_RATE = 1152);
  logic [31:0]         in;
  logic                in_ready;
  logic                is_last;
  logic [1:0]          byte_num;
  logic [1:0]          out_size;
  logic                buffer_full;
  logic [MAX_RATE-1:0] out;
  logic                out_ready;
  logic                f_ack;
  logic                last_block;
  logic [1:0]          out_size_q;

  modport master (
    output in, in_ready, is_last, byte_num, out_size, f_ack,
    input  buffer_full, out, out_ready, last_block, out_size_q
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, out_size, f_ack,
    output buffer_full, out, out_ready, last_block, out_size_q
  );
endinterface

// File: rtl/sha3_pad_word.sv
// sha3_pad_word: builds the 32-bit word shifted into the block buffer.
//   in         : message word, first byte in [31:24]
//   byte_num   : valid bytes in a last word (0..3)
//   is_last    : in is the final message word
//   pad_zero   : insert a padding-only word (PAD state)
//   final_slot : this word lands in the last slot of the block
//   word       : resulting word
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [1:0]        byte_num,
  input  logic              is_last,
  input  logic              pad_zero,
  input  logic              final_slot,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] keep_mask;
  logic [WORD_W-1:0] domain_bits;

  // Keep the valid leading bytes; the domain byte goes right after them.
  always_comb begin
    keep_mask   = '0;
    domain_bits = '0;
    case (byte_num)
      2'd0: begin
        keep_mask   = 32'h0000_0000;
        domain_bits = {PAD_DOMAIN, 24'h0};
      end
      2'd1: begin
        keep_mask   = 32'hFF00_0000;
        domain_bits = {8'h0, PAD_DOMAIN, 16'h0};
      end
      2'd2: begin
        keep_mask   = 32'hFFFF_0000;
        domain_bits = {16'h0, PAD_DOMAIN, 8'h0};
      end
      default: begin
        keep_mask   = 32'hFFFF_FF00;
        domain_bits = {24'h0, PAD_DOMAIN};
      end
    endcase
  end

  always_comb begin
    word = in;
    if (pad_zero) begin
      word = '0;
    end else if (is_last) begin
      word = (in & keep_mask) | domain_bits;
    end
    // The closing pad bit only exists in a padded block, never in plain data.
    if (final_slot && (pad_zero || is_last)) begin
      word[7:0] = word[7:0] | PAD_FINAL;
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// sha3_padder: accepts 32-bit message words, applies SHA-3 padding and
// presents rate-sized blocks (MSB-aligned to the rate) to the permutation.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sha3_padder_if slave (word input, block output, f_ack)
//   state_dbg  : current FSM state for observation
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int MAX_RATE = 1152
) (
  input  logic          clk,
  input  logic          reset,
  sha3_padder_if.slave  bus,
  output state_t        state_dbg
);

  state_t              state;
  logic [5:0]          count;
  logic [MAX_RATE-1:0] blk_q;
  logic                out_ready_q;
  logic                buffer_full_q;
  logic                last_q;
  logic [1:0]          size_q;
  logic                pad_done;
  logic                in_msg;      // a message is in progress; rate is locked

  logic [5:0]          n_words;
  logic                final_slot;
  logic [WORD_W-1:0]   pad_word;

  // The first word of a message uses the live rate select; it is latched
  // on that same edge, so slot arithmetic must not wait for size_q.
  assign n_words    = words_per_block(in_msg ? size_q : bus.out_size);
  assign final_slot = (count == n_words - 6'd1);

  sha3_pad_word u_pad_word (
    .in         (bus.in),
    .byte_num   (bus.byte_num),
    .is_last    (bus.is_last),
    .pad_zero   (state == PAD),
    .final_slot (final_slot),
    .word       (pad_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      count         <= '0;
      blk_q         <= '0;
      out_ready_q   <= 1'b0;
      buffer_full_q <= 1'b0;
      last_q        <= 1'b0;
      size_q        <= 2'd0;
      pad_done      <= 1'b0;
      in_msg        <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_ready) begin
            blk_q <= {blk_q[MAX_RATE-WORD_W-1:0], pad_word};
            count <= count + 6'd1;
            if (!in_msg) begin
              size_q <= bus.out_size;
              in_msg <= 1'b1;
            end
            if (bus.is_last) begin
              pad_done <= 1'b1;
            end
            if (final_slot) begin
              state         <= FULL;
              out_ready_q   <= 1'b1;
              buffer_full_q <= 1'b1;
              last_q        <= bus.is_last;
            end else if (bus.is_last) begin
              state         <= PAD;
              buffer_full_q <= 1'b1;
            end
          end
        end
        PAD: begin
          blk_q <= {blk_q[MAX_RATE-WORD_W-1:0], pad_word};
          count <= count + 6'd1;
          if (final_slot) begin
            state       <= FULL;
            out_ready_q <= 1'b1;
            last_q      <= pad_done;
          end
        end
        FULL: begin
          // Block is held until consumed; padding always fits in the
          // current block, so the next state is always FILL.
          if (bus.f_ack) begin
            state         <= FILL;
            out_ready_q   <= 1'b0;
            buffer_full_q <= 1'b0;
            last_q        <= 1'b0;
            count         <= '0;
            if (last_q) begin
              pad_done <= 1'b0;
              in_msg   <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.out         = blk_q;
  assign bus.out_ready   = out_ready_q;
  assign bus.buffer_full = buffer_full_q;
  assign bus.last_block  = last_q;
  assign bus.out_size_q  = size_q;
  assign state_dbg       = state;

endmodule
